// File: rtl/trap_seq.sv
// Machine-mode trap entry / mret return sequencer: picks one trap event, drains
// the data bus, strobes the mstatus update, flushes the front end and redirects fetch.
module trap_seq #(
  parameter int ADDR_WIDTH = 32,
  parameter int DRAIN_MAX  = 15
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic                  exception_met,
  input  logic                  valid_interrupt,
  input  logic                  mret,
  input  logic [ADDR_WIDTH-1:0] vector_addr,
  input  logic [ADDR_WIDTH-1:0] mepc,
  input  logic                  lsu_busy,
  input  logic                  fetch_ready,
  output logic                  pipe_stall,
  output logic                  pipe_flush,
  output logic                  trap_commit,
  output logic                  mret_commit,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  drain_timeout,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DRAIN_MAX + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_e;
  typedef enum logic [1:0] {KIND_EXC, KIND_INT, KIND_RET} kind_e;

  state_e           state, state_nxt;
  kind_e            kind, kind_nxt;
  logic [CNT_W-1:0] drain_cnt;
  logic             trigger;
  logic             drain_abort;
  logic             drain_hit;

  assign trigger     = exception_met | valid_interrupt | mret;
  // An interrupt that is withdrawn while draining has not flushed anything yet,
  // so the sequence can simply be abandoned.
  assign drain_abort = (kind == KIND_INT) && !valid_interrupt;
  assign drain_hit   = (drain_cnt == CNT_W'(DRAIN_MAX - 1));

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the clock edge.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state <= IDLE;
      kind  <= KIND_EXC;
    end else begin
      state <= state_nxt;
      kind  <= kind_nxt;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    kind_nxt  = kind;
    case (state)
      IDLE: begin
        if (trigger) begin
          if (exception_met)        kind_nxt = KIND_EXC;
          else if (valid_interrupt) kind_nxt = KIND_INT;
          else                      kind_nxt = KIND_RET;
          state_nxt = lsu_busy ? DRAIN : COMMIT;
        end
      end
      DRAIN: begin
        if (drain_abort)    state_nxt = IDLE;
        else if (!lsu_busy) state_nxt = COMMIT;
        else if (drain_hit) state_nxt = COMMIT;
      end
      COMMIT:   state_nxt = REDIRECT;
      REDIRECT: if (fetch_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Drain counter is cleared while idle and saturates, so it never wraps.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      drain_cnt <= '0;
    end else if (state == IDLE) begin
      drain_cnt <= '0;
    end else if (state == DRAIN && drain_cnt != CNT_W'(DRAIN_MAX)) begin
      drain_cnt <= drain_cnt + 1'b1;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      redirect_addr <= '0;
    end else if (state == COMMIT) begin
      redirect_addr <= (kind == KIND_RET) ? mepc : vector_addr;
    end
  end

  always_comb begin
    pipe_stall     = 1'b0;
    pipe_flush     = 1'b0;
    trap_commit    = 1'b0;
    mret_commit    = 1'b0;
    redirect_valid = 1'b0;
    drain_timeout  = 1'b0;
    busy           = (state != IDLE);
    case (state)
      DRAIN: begin
        pipe_stall    = 1'b1;
        // Flags the forced-commit transition in the last DRAIN cycle itself.
        drain_timeout = !drain_abort && lsu_busy && drain_hit;
      end
      COMMIT: begin
        pipe_flush  = 1'b1;
        trap_commit = (kind != KIND_RET);
        mret_commit = (kind == KIND_RET);
      end
      REDIRECT: begin
        pipe_flush     = 1'b1;
        redirect_valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_seq.sv
// Directed bench for trap_seq: stimulus queues expected strobes/redirects with
// their cycle numbers; a negedge monitor pops and compares them.
module tb_trap_seq;

  localparam int AW = 32;

  logic          cpu_clk = 1'b0;
  logic          cpu_rstn;
  logic          exception_met, valid_interrupt, mret;
  logic [AW-1:0] vector_addr, mepc;
  logic          lsu_busy, fetch_ready;
  logic          pipe_stall, pipe_flush, trap_commit, mret_commit;
  logic          redirect_valid, drain_timeout, busy;
  logic [AW-1:0] redirect_addr;

  typedef enum {EV_TIMEOUT, EV_TRAP, EV_MRET, EV_REDIR} ev_e;
  typedef struct {
    ev_e           ev;
    logic [AW-1:0] addr;
    int            cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   prev_strobe = 1'b0;

  trap_seq #(.ADDR_WIDTH(AW), .DRAIN_MAX(15)) dut (
    .cpu_clk        (cpu_clk),
    .cpu_rstn       (cpu_rstn),
    .exception_met  (exception_met),
    .valid_interrupt(valid_interrupt),
    .mret           (mret),
    .vector_addr    (vector_addr),
    .mepc           (mepc),
    .lsu_busy       (lsu_busy),
    .fetch_ready    (fetch_ready),
    .pipe_stall     (pipe_stall),
    .pipe_flush     (pipe_flush),
    .trap_commit    (trap_commit),
    .mret_commit    (mret_commit),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .drain_timeout  (drain_timeout),
    .busy           (busy)
  );

  always #5 cpu_clk = ~cpu_clk;
  always @(posedge cpu_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input ev_e ev, input logic [AW-1:0] addr, input int at);
    exp_t e;
    e.ev   = ev;
    e.addr = addr;
    e.cyc  = at;
    sb_q.push_back(e);
  endtask

  task automatic observe(input ev_e ev, input logic [AW-1:0] addr);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_%s: event at cycle %0d, nothing expected", ev.name(), cyc);
      return;
    end
    e = sb_q.pop_front();
    check({"event_kind_", e.ev.name()}, ev, e.ev);
    check({"event_cycle_", e.ev.name()}, cyc, e.cyc);
    if (e.ev == EV_REDIR) check("redirect_addr", addr, e.addr);
  endtask

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {pipe_stall, pipe_flush, trap_commit, mret_commit,
                 redirect_valid, drain_timeout, busy}, 0);
    check({name, "_addr"}, redirect_addr, 0);
  endtask

  // Monitor: compares every observable event against the scoreboard.
  initial begin
    forever begin
      @(negedge cpu_clk);
      if (drain_timeout)                observe(EV_TIMEOUT, '0);
      if (trap_commit)                  observe(EV_TRAP, '0);
      if (mret_commit)                  observe(EV_MRET, '0);
      if (redirect_valid && fetch_ready) observe(EV_REDIR, redirect_addr);
      if (trap_commit || mret_commit) begin
        check("strobe_exclusive", trap_commit && mret_commit, 0);
        check("strobe_back_to_back", prev_strobe, 0);
      end
      prev_strobe = trap_commit || mret_commit;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int stalls;
    exception_met = 0; valid_interrupt = 0; mret = 0;
    vector_addr = '0; mepc = '0; lsu_busy = 0; fetch_ready = 1;
    cpu_rstn = 0;
    #3;
    check_all_zero("reset_outputs");
    step(); step();
    cpu_rstn = 1;
    step();
    check_all_zero("post_reset_outputs");

    // 1: exception, no drain, fetch ready
    vector_addr = 32'h100; exception_met = 1; t = cyc;
    push(EV_TRAP, '0, t + 1); push(EV_REDIR, 32'h100, t + 2);
    step(); exception_met = 0;
    check("t1_flush_commit", pipe_flush, 1);
    step();
    check("t1_redirect_valid", redirect_valid, 1);
    step();
    check("t1_idle", busy, 0);

    // 2: interrupt with 3 cycles of data-bus drain
    vector_addr = 32'h200; valid_interrupt = 1; lsu_busy = 1; t = cyc;
    push(EV_TRAP, '0, t + 4); push(EV_REDIR, 32'h200, t + 5);
    step(); check("t2_stall1", pipe_stall, 1);
    step(); check("t2_stall2", pipe_stall, 1);
    step(); lsu_busy = 0; check("t2_stall3", pipe_stall, 1);
    step(); valid_interrupt = 0; check("t2_stall_off", pipe_stall, 0);
    step(); step();
    check("t2_idle", busy, 0);

    // 3: interrupt withdrawn in the 2nd DRAIN cycle -> abort, nothing flushed
    vector_addr = 32'h280; valid_interrupt = 1; lsu_busy = 1;
    step(); check("t3_stall1", pipe_stall, 1);
    step(); valid_interrupt = 0; check("t3_stall2", pipe_stall, 1);
    step();
    check("t3_idle", busy, 0);
    check("t3_no_flush", pipe_flush, 0);
    lsu_busy = 0;
    step();
    check("t3_still_idle", busy, 0);

    // 4: lsu_busy stuck -> timeout in the 15th DRAIN cycle
    vector_addr = 32'h300; exception_met = 1; lsu_busy = 1; t = cyc;
    push(EV_TIMEOUT, '0, t + 15); push(EV_TRAP, '0, t + 16); push(EV_REDIR, 32'h300, t + 17);
    step(); exception_met = 0;
    stalls = 0;
    for (int i = 0; i < 15; i++) begin
      if (pipe_stall) stalls++;
      step();
    end
    check("t4_stall_cycles", stalls, 15);
    check("t4_commit_flush", pipe_flush, 1);
    lsu_busy = 0;
    step(); step();
    check("t4_idle", busy, 0);

    // 5a: mret returns to mepc
    vector_addr = 32'h400; mepc = 32'h2004; mret = 1; t = cyc;
    push(EV_MRET, '0, t + 1); push(EV_REDIR, 32'h2004, t + 2);
    step(); mret = 0;
    step(); step();
    check("t5a_idle", busy, 0);

    // 5b: mret together with exception -> exception wins
    vector_addr = 32'h500; mepc = 32'h3000; mret = 1; exception_met = 1; t = cyc;
    push(EV_TRAP, '0, t + 1); push(EV_REDIR, 32'h500, t + 2);
    step(); mret = 0; exception_met = 0;
    step(); step();
    check("t5b_idle", busy, 0);

    // 6: fetch stalls for 4 REDIRECT cycles; trigger during REDIRECT ignored
    vector_addr = 32'h600; exception_met = 1; fetch_ready = 0; t = cyc;
    push(EV_TRAP, '0, t + 1); push(EV_REDIR, 32'h600, t + 6);
    step(); exception_met = 0;
    step(); vector_addr = 32'h777;
    for (int i = 0; i < 4; i++) begin
      check("t6_redirect_held_valid", redirect_valid, 1);
      check("t6_redirect_held_addr", redirect_addr, 32'h600);
      step();
    end
    fetch_ready = 1; mret = 1; mepc = 32'h800;
    step(); mret = 0;
    check("t6_idle", busy, 0);
    step();
    check("t6_trigger_ignored", busy, 0);

    // Reset asserted mid-REDIRECT clears every output asynchronously
    vector_addr = 32'h900; exception_met = 1; fetch_ready = 0; t = cyc;
    push(EV_TRAP, '0, t + 1);
    step(); exception_met = 0;
    step();
    check("rst_in_redirect", redirect_valid, 1);
    #2 cpu_rstn = 0;
    #1 check_all_zero("async_reset_outputs");
    step(); step();
    cpu_rstn = 1; fetch_ready = 1;
    step();
    check("rst_idle", busy, 0);

    step(); step();
    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
